// File: rtl/imem_boot_loader_pkg.sv
// Shared CPU package: MIPS opcode constants plus the boot-loader FSM
// encodings and the width of the stream length field.
package imem_boot_loader_pkg;

    // Existing primary opcode field values (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // Boot stream word-count field width
    localparam int LEN_W = 16;

    // Boot loader FSM encodings
    localparam logic [2:0] ST_LEN_HI = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

endpackage

// File: rtl/imem_boot_loader_byte_assembler.sv
// Byte-to-word assembler for the boot stream. Bytes arrive MSB first; the
// fourth byte of a group completes the word, which is presented
// combinationally together with a one-cycle word_valid.
//   clk        : clock
//   areset     : synchronous active-high reset, clears counter and shifter
//   en         : a byte is being transferred this cycle
//   byte_in    : the byte being transferred
//   word       : assembled big-endian word (valid when word_valid)
//   word_valid : high on the transfer of the 4th byte of a word
module imem_boot_loader_byte_assembler (
    input  logic        clk,
    input  logic        areset,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_p0;
    logic [23:0] sr_p0;

    // Only the three most recent bytes need storing; the fourth is taken
    // straight from the input so the word is ready on the completing cycle.
    always_ff @(posedge clk) begin
        if (areset) begin
            cnt_p0 <= 2'd0;
            sr_p0  <= 24'd0;
        end else if (en) begin
            cnt_p0 <= cnt_p0 + 2'd1;
            sr_p0  <= {sr_p0[15:0], byte_in};
        end
    end

    assign word       = {sr_p0, byte_in};
    assign word_valid = en && (cnt_p0 == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader. Receives a byte stream consisting of a
// 16-bit word count N (MSB first) followed by 4*N bytes of big-endian
// instructions and writes them to consecutive imem word addresses from 0.
// The downstream CPU is held in reset until the load completes.
//   clk, areset          : clock, synchronous active-high reset
//   in_data/valid/ready  : boot byte stream handshake
//   imem_we/addr/wdata   : registered instruction-memory write port
//   cpu_rst              : CPU reset, released only in DONE
//   done, err            : sticky completion / length-overflow flags
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    // Capacity in words, one bit wider than the length field so that a
    // 16-bit N can be compared against 2^ADDR_W without truncation.
    localparam logic [LEN_W:0] CAP = (LEN_W + 1)'(1) << ADDR_W;

    logic [2:0]        state;
    logic [7:0]        len_hi;
    logic [LEN_W-1:0]  words_left;
    logic [ADDR_W-1:0] widx;
    logic              xfer;
    logic [LEN_W-1:0]  n_full;
    logic [31:0]       word_p0;
    logic              vld_p0;

    // Reset forces in_ready low so a reset cycle can never look like a transfer.
    assign in_ready = !areset &&
                      ((state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA));
    assign xfer     = in_valid && in_ready;
    assign n_full   = {len_hi, in_data};

    imem_boot_loader_byte_assembler u_asm (
        .clk        (clk),
        .areset     (areset),
        .en         (xfer && (state == ST_DATA)),
        .byte_in    (in_data),
        .word       (word_p0),
        .word_valid (vld_p0)
    );

    // Stage p0 -> outputs: completed word is registered onto the imem port
    always_ff @(posedge clk) begin
        if (areset) begin
            state      <= ST_LEN_HI;
            len_hi     <= 8'd0;
            words_left <= '0;
            widx       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_LEN_HI: begin
                    if (xfer) begin
                        len_hi <= in_data;
                        state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        words_left <= n_full;
                        if (n_full == '0)
                            state <= ST_DONE;
                        else if ({1'b0, n_full} > CAP)
                            state <= ST_ERR;
                        else
                            state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (vld_p0) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= widx;
                        imem_wdata <= word_p0;
                        // The index is not advanced past the last word, so a
                        // full-capacity load never wraps back to address 0.
                        if (words_left == LEN_W'(1)) begin
                            state <= ST_DONE;
                        end else begin
                            words_left <= words_left - LEN_W'(1);
                            widx       <= widx + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE, ST_ERR: ;
                default: state <= ST_ERR;
            endcase
        end
    end

    assign done    = (state == ST_DONE);
    assign err     = (state == ST_ERR);
    assign cpu_rst = !done;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: ADDR_W=8 instance, index 1: ADDR_W=2 instance
    logic        areset[2];
    logic [7:0]  in_data[2];
    logic        in_valid[2];
    logic        rdy[2], we[2], crst[2], dn[2], er[2];
    logic [31:0] wd[2];
    logic [7:0]  a0;
    logic [1:0]  a1;

    imem_boot_loader #(.ADDR_W(8)) dut0 (
        .clk(clk), .areset(areset[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(rdy[0]), .imem_we(we[0]), .imem_addr(a0), .imem_wdata(wd[0]),
        .cpu_rst(crst[0]), .done(dn[0]), .err(er[0])
    );

    imem_boot_loader #(.ADDR_W(2)) dut1 (
        .clk(clk), .areset(areset[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(rdy[1]), .imem_we(we[1]), .imem_addr(a1), .imem_wdata(wd[1]),
        .cpu_rst(crst[1]), .done(dn[1]), .err(er[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (dut%0d) at %0t: got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input int d);
        return (d == 0) ? a0 : {6'd0, a1};
    endfunction

    // ---------------- behavioural model ----------------
    // The model only remembers which bytes were accepted since the last reset;
    // every expected output is derived from that byte list.
    int          cap[2]  = '{256, 4};
    int          k[2]    = '{0, 0};
    logic [7:0]  mem[2][0:63];
    logic [31:0] ld[2]   = '{32'd0, 32'd0};
    logic [7:0]  la[2]   = '{8'd0, 8'd0};
    bit          p_rst[2] = '{1'b0, 1'b0};
    bit          p_x[2]   = '{1'b0, 1'b0};
    logic [7:0]  p_b[2];

    logic [7:0]  log_a[2][0:15];
    logic [31:0] log_d[2][0:15];
    int          log_n[2] = '{0, 0};

    function automatic int nval(input int d);
        return int'({mem[d][0], mem[d][1]});
    endfunction
    function automatic bit m_done(input int d);
        return (k[d] >= 2) && (nval(d) <= cap[d]) && (k[d] == 2 + 4 * nval(d));
    endfunction
    function automatic bit m_err(input int d);
        return (k[d] >= 2) && (nval(d) > cap[d]);
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit exp_we;
            bit exp_rdy;
            exp_we = 1'b0;
            // apply what happened at the preceding rising edge
            if (p_rst[d]) begin
                k[d]  = 0;
                la[d] = 8'd0;
                ld[d] = 32'd0;
            end else if (p_x[d] && k[d] < 64) begin
                mem[d][k[d]] = p_b[d];
                k[d]++;
                if (k[d] > 2 && ((k[d] - 2) % 4) == 0) begin
                    exp_we = 1'b1;
                    la[d]  = 8'((k[d] - 2) / 4 - 1);
                    ld[d]  = {mem[d][k[d]-4], mem[d][k[d]-3], mem[d][k[d]-2], mem[d][k[d]-1]};
                end
            end
            exp_rdy = !areset[d] && !m_done(d) && !m_err(d);
            check("imem_we",    d, 32'(we[d]),       32'(exp_we));
            check("imem_addr",  d, 32'(addr_of(d)),  32'(la[d]));
            check("imem_wdata", d, wd[d],            ld[d]);
            check("done",       d, 32'(dn[d]),       32'(m_done(d)));
            check("err",        d, 32'(er[d]),       32'(m_err(d)));
            check("cpu_rst",    d, 32'(crst[d]),     32'(!m_done(d)));
            check("in_ready",   d, 32'(rdy[d]),      32'(exp_rdy));
            if (we[d] === 1'b1 && log_n[d] < 16) begin
                log_a[d][log_n[d]] = addr_of(d);
                log_d[d][log_n[d]] = wd[d];
                log_n[d]++;
            end
            // decide what the next rising edge will do
            p_rst[d] = areset[d];
            p_x[d]   = !areset[d] && in_valid[d] && exp_rdy;
            p_b[d]   = in_data[d];
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] sq[$];

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int d);
        areset[d] = 1'b1;
        cycles(1);
        areset[d] = 1'b0;
        log_n[d]  = 0;
    endtask

    task automatic send(input int d, input bit gap);
        for (int i = 0; i < sq.size(); i++) begin
            bit ok;
            int tries;
            ok    = 1'b0;
            tries = 0;
            in_data[d]  = sq[i];
            in_valid[d] = 1'b1;
            while (!ok && tries < 20) begin
                @(negedge clk);
                ok = rdy[d];
                @(posedge clk);
                #1;
                tries++;
            end
            check("send_accept", d, 32'(ok), 32'd1);
            in_valid[d] = 1'b0;
            if (gap) cycles(1);
        end
    endtask

    task automatic check_029_log(input int d, input int base);
        check("log_addr0", d, 32'(log_a[d][base]),     32'd0);
        check("log_data0", d, log_d[d][base],          32'h2008_0005);
        check("log_addr1", d, 32'(log_a[d][base + 1]), 32'd1);
        check("log_data1", d, log_d[d][base + 1],      32'h0109_5020);
    endtask

    logic [31:0] exp_f[4] = '{32'h0010_2030, 32'h0111_2131, 32'h0212_2232, 32'h0313_2333};

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            areset[d]   = 1'b1;
            in_data[d]  = 8'd0;
            in_valid[d] = 1'b0;
        end
        cycles(1);
        // reset state, still inside reset
        check("rst_done",    0, 32'(dn[0]),   32'd0);
        check("rst_err",     0, 32'(er[0]),   32'd0);
        check("rst_cpu_rst", 0, 32'(crst[0]), 32'd1);
        check("rst_we",      0, 32'(we[0]),   32'd0);
        check("rst_wdata",   0, wd[0],        32'd0);
        check("rst_ready",   0, 32'(rdy[0]),  32'd0);
        areset[0] = 1'b0;
        areset[1] = 1'b0;
        cycles(1);

        // two-word program, continuous valid
        do_reset(0);
        sq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        send(0, 1'b0);
        check("A_done_next", 0, 32'(dn[0]),   32'd1);
        check("A_cpurst",    0, 32'(crst[0]), 32'd0);
        check("A_we_last",   0, 32'(we[0]),   32'd1);
        cycles(2);
        check("A_nwrites", 0, 32'(log_n[0]), 32'd2);
        check_029_log(0, 0);
        // DONE ignores further bytes
        in_data[0]  = 8'hAA;
        in_valid[0] = 1'b1;
        cycles(4);
        in_valid[0] = 1'b0;
        check("A_absorb_writes", 0, 32'(log_n[0]), 32'd2);
        check("A_absorb_ready",  0, 32'(rdy[0]),   32'd0);

        // empty program
        do_reset(0);
        sq = '{8'h00, 8'h00};
        send(0, 1'b0);
        check("B_done",    0, 32'(dn[0]),   32'd1);
        check("B_cpurst",  0, 32'(crst[0]), 32'd0);
        cycles(3);
        check("B_ready",   0, 32'(rdy[0]),  32'd0);
        check("B_nwrites", 0, 32'(log_n[0]), 32'd0);

        // same program with in_valid toggling
        do_reset(0);
        sq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        send(0, 1'b1);
        cycles(2);
        check("C_done",    0, 32'(dn[0]),    32'd1);
        check("C_nwrites", 0, 32'(log_n[0]), 32'd2);
        check_029_log(0, 0);

        // reset after 6 data bytes, then full program
        do_reset(0);
        sq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09};
        send(0, 1'b0);
        cycles(2);
        areset[0] = 1'b1;
        cycles(1);
        areset[0] = 1'b0;
        check("D_abort_done", 0, 32'(dn[0]), 32'd0);
        sq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        send(0, 1'b0);
        cycles(2);
        check("D_nwrites", 0, 32'(log_n[0]), 32'd3);
        check("D_first_addr", 0, 32'(log_a[0][0]), 32'd0);
        check("D_first_data", 0, log_d[0][0],      32'h2008_0005);
        check_029_log(0, 1);
        check("D_done", 0, 32'(dn[0]), 32'd1);

        // ADDR_W=2: N=5 overflows capacity 4
        do_reset(1);
        sq = '{8'h00, 8'h05};
        send(1, 1'b0);
        check("E_err",    1, 32'(er[1]),   32'd1);
        check("E_cpurst", 1, 32'(crst[1]), 32'd1);
        check("E_ready",  1, 32'(rdy[1]),  32'd0);
        cycles(3);
        check("E_nwrites", 1, 32'(log_n[1]), 32'd0);
        check("E_done",    1, 32'(dn[1]),    32'd0);

        // ADDR_W=2: N=4 fills memory exactly
        do_reset(1);
        sq = '{8'h00, 8'h04,
               8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31,
               8'h02, 8'h12, 8'h22, 8'h32, 8'h03, 8'h13, 8'h23, 8'h33};
        send(1, 1'b0);
        cycles(3);
        check("F_nwrites", 1, 32'(log_n[1]), 32'd4);
        for (int w = 0; w < 4; w++) begin
            check("F_addr", 1, 32'(log_a[1][w]), 32'(w));
            check("F_data", 1, log_d[1][w],      exp_f[w]);
        end
        check("F_done", 1, 32'(dn[1]), 32'd1);
        check("F_err",  1, 32'(er[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
